// File: rtl/if_map_ctrl.sv
// if_map_ctrl: sequencing controller for the input-feature-map address generator.
// Loads a per-row start/end table through a valid/ready config port, then on
// start walks every configured row: load head, sweep kernel offsets, step head
// by the stride until the row-end compare fires, advance the row pointer until
// the last row completes. Reads leave through a valid/ready handshake.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   cfg_valid/cfg_last/cfg_ready config beat handshake (row data goes straight to datapath)
//   start, kernel_last          run request, last kernel offset (latched on start)
//   row_end, finish_row         datapath compares (head+filter==end, row_ptr==last_row)
//   ld_input_head, sel, offset  head register control and kernel offset
//   ld_start, ld_end            start/end RAM writes at current row pointer
//   row_ptr_cnt_en, clr_row_ptr, ld_row_ptr  row-pointer counter / last-row register
//   rd_valid, rd_ready          read handshake; win_first/win_last qualify the read
//   busy, done, cfg_loaded, cfg_trunc        status
//
// ld_start, ld_end, row_ptr_cnt_en and ld_row_ptr are combinational: they must
// coincide with the config beat / compare result they act on. Everything else
// is registered.
module if_map_ctrl #(
  parameter int unsigned MAX_ROW       = 2,
  parameter int unsigned STRIDE_SIZE   = 2,
  parameter int unsigned ROW_PTR_WIDTH = (MAX_ROW > 1) ? $clog2(MAX_ROW) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_valid,
  input  logic                   cfg_last,
  output logic                   cfg_ready,
  input  logic                   start,
  input  logic [STRIDE_SIZE-1:0] kernel_last,
  input  logic                   row_end,
  input  logic                   finish_row,
  output logic                   ld_input_head,
  output logic                   sel,
  output logic [STRIDE_SIZE-1:0] offset,
  output logic                   ld_start,
  output logic                   ld_end,
  output logic                   row_ptr_cnt_en,
  output logic                   clr_row_ptr,
  output logic                   ld_row_ptr,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic                   win_first,
  output logic                   win_last,
  output logic                   busy,
  output logic                   done,
  output logic                   cfg_loaded,
  output logic                   cfg_trunc
);

  localparam logic [ROW_PTR_WIDTH-1:0] LAST_IDX = ROW_PTR_WIDTH'(MAX_ROW - 1);

  typedef enum logic [2:0] {
    IDLE, ARM, LOAD_HEAD, SWEEP, STEP, NEXT_ROW, DONE
  } state_t;

  state_t                   state;
  logic [STRIDE_SIZE-1:0]   kernel_last_q;
  logic [ROW_PTR_WIDTH-1:0] cfg_idx;

  logic                     cfg_accept_c;
  logic                     beat_last_c;
  logic [STRIDE_SIZE-1:0]   offset_inc_c;

  // Config beat acceptance; a beat is last when flagged or when the RAMs are full.
  assign cfg_accept_c = cfg_valid && cfg_ready;
  assign beat_last_c  = cfg_last || (cfg_idx == LAST_IDX);
  assign offset_inc_c = offset + STRIDE_SIZE'(1);

  // Datapath strobes that must line up with the current beat / compare.
  assign ld_start       = cfg_accept_c;
  assign ld_end         = cfg_accept_c;
  assign ld_row_ptr     = cfg_accept_c && beat_last_c;
  assign row_ptr_cnt_en = cfg_accept_c || ((state == NEXT_ROW) && !finish_row);

  // Controller state and registered outputs (each branch sets outputs for the next state).
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cfg_ready     <= 1'b1;
      ld_input_head <= 1'b0;
      sel           <= 1'b0;
      offset        <= '0;
      clr_row_ptr   <= 1'b0;
      rd_valid      <= 1'b0;
      win_first     <= 1'b0;
      win_last      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      cfg_loaded    <= 1'b0;
      cfg_trunc     <= 1'b0;
      kernel_last_q <= '0;
      cfg_idx       <= '0;
    end else begin
      cfg_ready     <= 1'b0;
      ld_input_head <= 1'b0;
      sel           <= 1'b0;
      clr_row_ptr   <= 1'b0;
      rd_valid      <= 1'b0;
      win_first     <= 1'b0;
      win_last      <= 1'b0;
      done          <= 1'b0;

      case (state)
        IDLE: begin
          cfg_ready <= 1'b1;
          if (cfg_accept_c) begin
            // First beat of a new table invalidates the previous one.
            if (cfg_idx == '0) begin
              cfg_loaded <= 1'b0;
              cfg_trunc  <= 1'b0;
            end
            if (beat_last_c) begin
              state       <= ARM;
              cfg_ready   <= 1'b0;
              clr_row_ptr <= 1'b1;
              cfg_idx     <= '0;
              if (!cfg_last) cfg_trunc <= 1'b1;
            end else begin
              cfg_idx <= cfg_idx + ROW_PTR_WIDTH'(1);
            end
          end else if (start && cfg_loaded) begin
            state         <= LOAD_HEAD;
            cfg_ready     <= 1'b0;
            kernel_last_q <= kernel_last;
            busy          <= 1'b1;
            ld_input_head <= 1'b1;
            sel           <= 1'b1;
          end
        end

        ARM: begin
          state      <= IDLE;
          cfg_ready  <= 1'b1;
          cfg_loaded <= 1'b1;
        end

        LOAD_HEAD, STEP: begin
          state     <= SWEEP;
          rd_valid  <= 1'b1;
          win_first <= 1'b1;
          win_last  <= (kernel_last_q == '0);
        end

        SWEEP: begin
          rd_valid  <= 1'b1;
          win_first <= win_first;
          win_last  <= win_last;
          if (rd_ready) begin
            if (win_last) begin
              rd_valid  <= 1'b0;
              win_first <= 1'b0;
              win_last  <= 1'b0;
              offset    <= '0;
              if (row_end) begin
                state <= NEXT_ROW;
              end else begin
                state         <= STEP;
                ld_input_head <= 1'b1;
              end
            end else begin
              offset    <= offset_inc_c;
              win_first <= 1'b0;
              win_last  <= (offset_inc_c == kernel_last_q);
            end
          end
        end

        NEXT_ROW: begin
          if (finish_row) begin
            state       <= DONE;
            done        <= 1'b1;
            clr_row_ptr <= 1'b1;
          end else begin
            state         <= LOAD_HEAD;
            ld_input_head <= 1'b1;
            sel           <= 1'b1;
          end
        end

        DONE: begin
          state     <= IDLE;
          cfg_ready <= 1'b1;
          busy      <= 1'b0;
        end

        default: begin
          state     <= IDLE;
          cfg_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
